// File: rtl/uart_transmitter_pkg.sv
// Shared UART transmit/receive definitions.
// FSM state type and bit-period helper.
`ifndef BAUD_RATE
`define BAUD_RATE 115_200
`endif

package uart_transmitter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } UartTxState_t;

  // Clocks per bit, rounded to nearest.
  function automatic int calc_bit_cycles(
    input int clk_hz,
    input int baud
  );
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter.
// Ports: push/din in, pop/dout out, full, empty, count.
module uart_tx_fifo #(
  parameter int Depth = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [7:0]                   din,
  output logic [7:0]                   dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(Depth+1)-1:0]   count
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth + 1);

  logic [7:0]      mem [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter fed by a byte FIFO.
// Ports: wrEn/wrData in; full, count, overflow, busy, TxD out.
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int ClkFrequency = 100_000_000,
  parameter int Baud         = `BAUD_RATE,
  parameter int FifoDepth    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wrEn,
  input  logic [7:0]                       wrData,
  output logic                             full,
  output logic [$clog2(FifoDepth+1)-1:0]   count,
  output logic                             overflow,
  output logic                             busy,
  output logic                             TxD
);

  localparam int BitCycles =
    calc_bit_cycles(ClkFrequency, Baud);
  localparam int BcW =
    (BitCycles > 1) ? $clog2(BitCycles) : 1;
  localparam logic [BcW-1:0] BitLast =
    BcW'(BitCycles - 1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_START = START;
  localparam logic [1:0] S_DATA  = DATA;
  localparam logic [1:0] S_STOP  = STOP;

  logic [1:0]     state;
  logic [BcW-1:0] bit_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;
  logic [7:0]     head;
  logic           empty;
  logic           bit_end;
  logic           pop;
  logic           push;

  assign bit_end = (bit_cnt == BitLast);
  assign push    = wrEn && !full;
  // Fetch next byte from IDLE, or straight
  // from the last STOP clock for gapless frames.
  assign pop = !empty &&
    ((state == S_IDLE) ||
     ((state == S_STOP) && bit_end));
  assign busy = (state != S_IDLE) || (count != '0);

  uart_tx_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .pop   (pop),
    .din   (wrData),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // A drop is recorded even if a pop frees
  // a slot on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overflow <= 1'b0;
    else if (wrEn && full) overflow <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      TxD     <= 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            shift   <= head;
            bit_cnt <= '0;
            state   <= S_START;
            TxD     <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            state   <= S_DATA;
            TxD     <= shift[0];
          end else begin
            bit_cnt <= bit_cnt + BcW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
              TxD   <= 1'b1;
            end else begin
              TxD <= shift[1];
            end
          end else begin
            bit_cnt <= bit_cnt + BcW'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (pop) begin
              shift <= head;
              state <= S_START;
              TxD   <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + BcW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter.
// Line model plus a loopback frame decoder.
module tb_uart_transmitter;

  localparam int ClkFreq   = 1_000_000;
  localparam int BaudR     = 100_000;
  localparam int Depth     = 16;
  localparam int BitCycles = 10;
  localparam int Frame     = 10 * BitCycles;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wrEn = 1'b0;
  logic [7:0] wrData = 8'h00;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       busy;
  logic       TxD;

  int tests_run = 0;
  int fails = 0;
  logic [7:0] rx_q[$];
  int rx_frame_err = 0;

  always #5 clk = ~clk;

  uart_transmitter #(
    .ClkFrequency (ClkFreq),
    .Baud         (BaudR),
    .FifoDepth    (Depth)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wrEn     (wrEn),
    .wrData   (wrData),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .busy     (busy),
    .TxD      (TxD)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: sim time exceeded, required finish");
    $fatal(1, "watchdog");
  end

  // Loopback receiver: samples mid-bit, aborts on reset.
  initial begin
    logic prev;
    logic ok;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst && prev === 1'b1 && TxD === 1'b0) begin
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          if (!rst) ok = 1'b0;
        end
        if (TxD !== 1'b0) ok = 1'b0;
        for (int k = 0; k < 9; k++) begin
          for (int i = 0; i < BitCycles; i++) begin
            @(negedge clk);
            if (!rst) ok = 1'b0;
          end
          if (k < 8) b[k] = TxD;
          else if (ok && TxD !== 1'b1) rx_frame_err++;
        end
        if (ok) rx_q.push_back(b);
      end
      prev = TxD;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level t clocks after the first START edge,
  // for back-to-back frames of the given bytes.
  function automatic logic exp_bit(
    input logic [7:0] b[$],
    input int t
  );
    int f;
    int pos;
    f = t / Frame;
    pos = (t % Frame) / BitCycles;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[f][pos-1];
  endfunction

  function automatic int first_diff(
    input logic [7:0] a[$],
    input logic [7:0] b[$]
  );
    if (a.size() != b.size()) return 999;
    foreach (a[i]) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  task automatic write_bytes(input logic [7:0] b[$]);
    foreach (b[i]) begin
      wrEn = 1'b1;
      wrData = b[i];
      tick();
    end
    wrEn = 1'b0;
  endtask

  // Called #1 after the edge preceding the first START.
  task automatic check_line(
    input logic [7:0] b[$],
    input int total,
    input string name
  );
    int bad = 0;
    int cbad = 0;
    int bt = -1;
    logic act = 1'b0;
    logic req = 1'b0;
    logic [4:0] ec;
    logic [4:0] cact = '0;
    logic [4:0] creq = '0;
    for (int t = 0; t < b.size() * Frame; t++) begin
      tick();
      if (TxD !== exp_bit(b, t)) begin
        if (bad == 0) begin
          bt = t; act = TxD; req = exp_bit(b, t);
        end
        bad++;
      end
      if (total > 0 && t > 0 && t % Frame == 0) begin
        ec = 5'(total - t / Frame - 1);
        if (count !== ec) begin
          if (cbad == 0) begin cact = count; creq = ec; end
          cbad++;
        end
      end
    end
    tests_run++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s line: TxD=%b at t=%0d, required %b (%0d bad)",
               name, act, bt, req, bad);
    end
    if (total > 0) begin
      tests_run++;
      if (cbad != 0) begin
        fails++;
        $display("FAIL %s count: %0d, required %0d",
                 name, cact, creq);
      end
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    rst = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    tests_run++;
    if (TxD !== 1'b1) begin
      fails++; $display("FAIL reset TxD: %b, required 1", TxD);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL reset busy: %b, required 0", busy);
    end
    tests_run++;
    if (full !== 1'b0) begin
      fails++; $display("FAIL reset full: %b, required 0", full);
    end
    tests_run++;
    if (count !== 5'd0) begin
      fails++; $display("FAIL reset count: %0d, required 0", count);
    end
    tests_run++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset overflow: %b, required 0", overflow);
    end
    for (int i = 0; i < 200; i++) begin
      tick();
      if (TxD !== 1'b1) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      fails++;
      $display("FAIL reset idle: %0d cycles TxD!=1, required 0", bad);
    end
  endtask

  task automatic run_frames(
    input logic [7:0] b[$],
    input string name
  );
    rx_q.delete();
    fork
      write_bytes(b);
      begin
        tick();
        tests_run++;
        if (TxD !== 1'b1 || busy !== 1'b1) begin
          fails++;
          $display("FAIL %s pre: TxD=%b busy=%b, required 1 1",
                   name, TxD, busy);
        end
        check_line(b, (b.size() > 1) ? b.size() : 0, name);
      end
    join
    tests_run++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL %s busy_stop: %b, required 1", name, busy);
    end
    tick();
    tests_run++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s busy_end: %b, required 0", name, busy);
    end
    tests_run++;
    if (first_diff(rx_q, b) != -1) begin
      fails++;
      $display("FAIL %s loopback: %0d bytes, required %0d",
               name, rx_q.size(), b.size());
    end
  endtask

  task automatic test_single();
    logic [7:0] b[$];
    b = '{8'h41};
    run_frames(b, "single");
    repeat (3) begin
      b = '{8'($urandom_range(0, 255))};
      run_frames(b, "single_rand");
      repeat ($urandom_range(1, 5)) tick();
    end
  endtask

  task automatic test_burst();
    logic [7:0] b[$];
    b = '{8'h1B, 8'h5B, 8'h36, 8'h6E};
    run_frames(b, "burst");
    b.delete();
    repeat (3) b.push_back(8'($urandom_range(0, 255)));
    run_frames(b, "burst_rand");
  endtask

  task automatic test_overflow();
    logic [7:0] acc[$];
    for (int i = 0; i < 17; i++) acc.push_back(8'(i));
    rx_q.delete();
    fork
      begin
        for (int i = 0; i < 18; i++) begin
          wrEn = 1'b1;
          wrData = 8'(i);
          tick();
          if (i == 15) begin
            tests_run++;
            if (full !== 1'b0 || count !== 5'd15) begin
              fails++;
              $display("FAIL ovf_16th: full=%b count=%0d, required 0 15",
                       full, count);
            end
          end
          if (i == 16) begin
            tests_run++;
            if (full !== 1'b1 || count !== 5'd16) begin
              fails++;
              $display("FAIL ovf_17th: full=%b count=%0d, required 1 16",
                       full, count);
            end
          end
        end
        wrEn = 1'b0;
        tests_run++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
          fails++;
          $display("FAIL ovf_flag: ovf=%b count=%0d, required 1 16",
                   overflow, count);
        end
      end
      begin
        tick();
        check_line(acc, 17, "overflow");
      end
    join
    tick();
    tests_run++;
    if (first_diff(rx_q, acc) != -1) begin
      fails++;
      $display("FAIL ovf_loopback: %0d bytes, required 17",
               rx_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b[$];
    int bad = 0;
    repeat (3) b.push_back(8'($urandom_range(0, 255)));
    b[0][3] = 1'b0;
    rx_q.delete();
    write_bytes(b);
    repeat (43) tick();
    tests_run++;
    if (TxD !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_bit3: TxD=%b, required 0", TxD);
    end
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if (TxD !== 1'b1 || count !== 5'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_async: TxD=%b count=%0d busy=%b, required 1 0 0",
               TxD, count, busy);
    end
    repeat (3) tick();
    rst = 1'b1;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (TxD !== 1'b1 || busy !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      fails++;
      $display("FAIL rstmid_quiet: %0d active cycles, required 0", bad);
    end
    tests_run++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_ovf: %b, required 0", overflow);
    end
    tests_run++;
    if (rx_q.size() != 0) begin
      fails++;
      $display("FAIL rstmid_rx: %0d frames, required 0", rx_q.size());
    end
  endtask

  task automatic test_stop_edge();
    logic [7:0] a[$];
    logic [7:0] s[$];
    a = '{8'($urandom_range(0, 255))};
    s = '{8'h55};
    fork
      write_bytes(a);
      begin tick(); check_line(a, 0, "stopedge_first"); end
    join
    wrEn = 1'b1;
    wrData = 8'h55;
    tick();
    wrEn = 1'b0;
    tests_run++;
    if (TxD !== 1'b1 || busy !== 1'b1 || count !== 5'd1) begin
      fails++;
      $display("FAIL stopedge_idle: TxD=%b busy=%b count=%0d, required 1 1 1",
               TxD, busy, count);
    end
    check_line(s, 0, "stopedge_55");
    tick();
    tests_run++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL stopedge_busy: %b, required 0", busy);
    end
  endtask

  task automatic test_random_gaps();
    logic [7:0] b[$];
    int n;
    int c;
    n = $urandom_range(3, 8);
    rx_q.delete();
    for (int i = 0; i < n; i++) begin
      b.push_back(8'($urandom_range(0, 255)));
      wrEn = 1'b1;
      wrData = b[i];
      tick();
      wrEn = 1'b0;
      repeat ($urandom_range(0, 120)) tick();
    end
    c = 0;
    while (busy && c < 3000) begin tick(); c++; end
    tests_run++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL gaps_timeout: busy=%b, required 0", busy);
    end
    repeat (20) tick();
    tests_run++;
    if (first_diff(rx_q, b) != -1) begin
      fails++;
      $display("FAIL gaps_loopback: %0d bytes, required %0d",
               rx_q.size(), n);
    end
    tests_run++;
    if (rx_frame_err != 0) begin
      fails++;
      $display("FAIL stop_bits: %0d bad stops, required 0",
               rx_frame_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_reset_mid();
    test_stop_edge();
    test_random_gaps();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Transmit-side counterpart of the terminal's asynchronous UART receiver.
- Accepts bytes from the VT100 parser, such as device-status and cursor-position reports, through a write-only FIFO interface.
- Serialises each byte as an 8N1 frame on TxD at the configured baud rate.
- Lives in the clk100M domain, next to the receiver, and drives the board UART TX pin.

Parameters:
- ClkFrequency, 100_000_000: input clock frequency in Hz.
- Baud, `BAUD_RATE: line rate in bit/s.
- FifoDepth, 16: byte FIFO depth; must be a power of two and at least 2.

Ports:
- clk  input  1  system clock (clk100M domain).
- rst  input  1  asynchronous, active-low reset.
- wrEn  input  1  write strobe; one byte per cycle.
- wrData  input  8  byte to enqueue.
- full  output  1  FIFO full; a write while high is dropped.
- count  output  $clog2(FifoDepth+1)  current FIFO occupancy.
- overflow  output  1  sticky flag: a write was dropped.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- TxD  output  1  serial output; idle level is 1.

Behaviour:
- Bit period: BitCycles = (ClkFrequency + Baud/2) / Baud clocks, with integer rounding. For 100 MHz and 115200 baud this is 868.
- The bit counter restarts at the start of every bit. There is no drift accumulation across frames.
- Reset (rst low, asynchronous): TxD=1, full=0, count=0, overflow=0, busy=0, FSM=IDLE, FIFO pointers=0. The reset takes effect immediately, including mid-frame; a partial frame is abandoned and the FIFO contents are discarded.
- Write handling:
  - wrEn sampled high with full=0 enqueues wrData at that edge.
  - wrEn high with full=1 drops the byte and sets overflow at that edge. This holds even if a pop occurs on the same edge.
  - overflow is cleared only by reset.
- Flags: full=(count==FifoDepth) and busy=(state!=IDLE)||(count!=0), both combinational from registers. TxD is registered.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - If count!=0, pop the head byte into the 8-bit shift register, then enter START with bitCnt=0.
  - A write at edge k into an empty FIFO therefore gives TxD=0 after edge k+1.
- START: TxD=0 for BitCycles clocks, then DATA with bitIdx=0.
- DATA:
  - TxD=shift[0] for BitCycles clocks per bit, LSB first.
  - After each bit, shift right and increment bitIdx.
  - After bit 7, go to STOP.
- STOP: TxD=1 for BitCycles clocks.
- End of STOP:
  - If count!=0 at that edge, pop and go directly to START (back-to-back frames, zero idle cycles).
  - Otherwise go to IDLE.
  - A write landing on the final STOP edge is not yet visible, so exactly one IDLE cycle precedes its START.
- Frame length is 10*BitCycles clocks.
- Simultaneous push and pop on the same edge: count is unchanged and both pointers advance mod FifoDepth.
- Pointers are $clog2(FifoDepth) bits and wrap naturally.

Decomposition:
- Shared package:
  - UartTxState_t enum {IDLE, START, DATA, STOP}.
  - A constant function computing BitCycles from ClkFrequency and Baud, reused by the receiver.
  - `BAUD_RATE remains in DataType.svh.
- Sub-module: uart_tx_fifo.
  - Synchronous byte FIFO with registered pointers and count.
  - Ports: push, pop, din, dout, full, empty, count.
  - Same asynchronous active-low reset.
- The top level contains only the baud counter, shift register and FSM.

Test Plan:
All runs use ClkFrequency=1_000_000 and Baud=100_000, giving BitCycles=10, unless noted.
1. Reset check: hold rst=0 for 5 cycles, release -> TxD=1, busy=0, full=0, count=0, overflow=0; TxD stays 1 for 200 idle cycles.
2. Single byte: write 0x41 at edge k -> TxD=0 from edge k+1 for 10 cycles, then bits 1,0,0,0,0,0,1,0 for 10 cycles each, then stop=1 for 10 cycles; busy falls at edge k+101.
3. Burst: write 0x1B,0x5B,0x36,0x6E on 4 consecutive cycles -> three contiguous frames after the first with no idle gap; total 400 cycles of activity; receiver loopback recovers the identical 4 bytes.
4. Overflow (FifoDepth=16): write 18 bytes 0x00..0x11 on consecutive cycles from idle -> full=1 after the 17th write, 0x11 dropped, overflow=1; bytes 0x00..0x10 transmitted in order; count decrements once per 100 cycles.
5. Reset mid-frame: 3 bytes queued, assert rst during DATA bit 3 of the first frame -> TxD=1 asynchronously, count=0; after release no frame is emitted for 500 cycles; overflow=0.
6. Stop-edge write: FIFO empty, write 0x55 on the final STOP cycle of the preceding frame -> exactly 1 IDLE cycle (TxD=1), then START; the line pattern of 0x55 is correct.
